controle_rodadas: RTL
=====================

CONTROLE_RODADAS -- requirements
Module: controle_rodadas

Interface
REQ-001 Parameter NUM_JOGADORES, 8, number of players visited per night (2..32).
REQ-002 Parameter JW, 5, width of jogador_atual; SHALL satisfy 2**JW >= NUM_JOGADORES.
REQ-003 Parameter TEMPO_W, 8, width of phase timer.
REQ-004 Parameter TEMPO_TURNO, 30, night-turn timer load value (ticks).
REQ-005 Parameter TEMPO_DIA, 120, day-discussion timer load value (ticks).
REQ-006 Parameter RODADA_W, 4, width of round counter.
REQ-007 clock  in  1  system clock; all state changes on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 jogar  in  1  start/restart request.
REQ-010 passa  in  1  player confirm/advance, level-sampled each cycle.
REQ-011 tick  in  1  one-cycle timebase pulse for the phase timer.
REQ-012 fim_jogo  in  1  datapath reports a winning condition.
REQ-013 rst_global, zera_CS  out  1 each  datapath clears; high in INICIAL, RESETA_TUDO.
REQ-014 e_seed_reg  out  1  seed register enable; high only in ARMAZENA_JOGO.
REQ-015 noite / dia / votacao  out  1 each  high in TURNO_NOITE / DISCUSSAO / VOTACAO respectively.
REQ-016 timeout  out  1  one-cycle pulse when a timed phase ends by expiry.
REQ-017 jogador_atual  out  JW  index of the player whose night turn is active.
REQ-018 rodada  out  RODADA_W  completed day/night rounds.
REQ-019 db_estado  out  5  state code per REQ-020; 5'b11111 for any unlisted code.

Function
REQ-020 States/codes: INICIAL 0, RESETA_TUDO 1, PREPARA_JOGO 2, ARMAZENA_JOGO 3, PREPARA_JOGO_2 4, PREPARA_NOITE 5, TURNO_NOITE 6, PROX_JOGADOR 7, PREPARA_DIA 8, DISCUSSAO 9, VOTACAO 10, APURA 11, FIM 12.
REQ-021 INICIAL->RESETA_TUDO on jogar; RESETA_TUDO->PREPARA_JOGO unconditionally.
REQ-022 PREPARA_JOGO->ARMAZENA_JOGO on passa; ARMAZENA_JOGO->PREPARA_JOGO_2->PREPARA_NOITE unconditionally.
REQ-023 PREPARA_NOITE: jogador_atual<=0, timer<=TEMPO_TURNO, ->TURNO_NOITE.
REQ-024 TURNO_NOITE: passa or timer expiry ->PROX_JOGADOR.
REQ-025 PROX_JOGADOR: if jogador_atual==NUM_JOGADORES-1 ->PREPARA_DIA; else jogador_atual+1, timer<=TEMPO_TURNO, ->TURNO_NOITE.
REQ-026 PREPARA_DIA: timer<=TEMPO_DIA, ->DISCUSSAO; DISCUSSAO: passa or expiry ->VOTACAO.
REQ-027 VOTACAO->APURA on passa only (no timer).
REQ-028 APURA: rodada increments, saturating at all-ones; fim_jogo ->FIM else ->PREPARA_NOITE.
REQ-029 FIM: jogar ->RESETA_TUDO; rodada and jogador_atual hold until RESETA_TUDO clears them to 0.
REQ-030 Timer: down-counter, decrements by 1 on tick only in TURNO_NOITE/DISCUSSAO while nonzero; expiry = counter==0 in those states.
REQ-031 passa and expiry in the same cycle: single transition, timeout stays 0.
REQ-032 timeout asserts in the cycle the FSM leaves a timed state by expiry alone.
REQ-033 Unlisted state code: next state INICIAL.
REQ-034 All outputs except jogador_atual, rodada, timeout are Moore decodes of the current state.

Reset
REQ-035 reset SHALL force state INICIAL, timer 0, jogador_atual 0, rodada 0, timeout 0 immediately, including mid-round.
REQ-036 After reset release, rst_global=zera_CS=1, all other 1-bit outputs 0, db_estado=0.

Configuration
REQ-037 Macro TEMPORIZADOR_EN defined: timer per REQ-030..032 present.
REQ-038 TEMPORIZADOR_EN undefined: no timer logic; TURNO_NOITE/DISCUSSAO exit only on passa; tick ignored; timeout tied 0.

Verification
REQ-039 reset; jogar 1 cycle; passa 1 cycle -> db_estado 0,1,2,3,4,5,6; e_seed_reg high exactly in state 3.
REQ-040 NUM_JOGADORES=4, passa pulses in night -> jogador_atual 0,1,2,3 then db_estado 8, 9.
REQ-041 TEMPO_TURNO=3, tick every cycle, no passa -> after 3 ticks timeout pulses once, state 7, jogador_atual advances.
REQ-042 APURA with fim_jogo=1 -> FIM, rodada=1; jogar -> RESETA_TUDO, rodada=0.
REQ-043 Timer reaches 0 while passa=1 -> state 7, timeout=0.
REQ-044 reset asserted in DISCUSSAO with rodada=2 -> db_estado=0, rodada=0 before next clock edge.

Source files
------------

// File: rtl/controle_rodadas.sv
// Round sequencer for the night/day game flow: night turns per player, day discussion, vote, tally.
// Optional phase timer enabled by defining TEMPORIZADOR_EN.
module controle_rodadas #(
  parameter int NUM_JOGADORES = 8,
  parameter int JW            = 5,
  parameter int TEMPO_W       = 8,
  parameter int TEMPO_TURNO   = 30,
  parameter int TEMPO_DIA     = 120,
  parameter int RODADA_W      = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                passa,
  input  logic                tick,
  input  logic                fim_jogo,
  output logic                rst_global,
  output logic                zera_CS,
  output logic                e_seed_reg,
  output logic                noite,
  output logic                dia,
  output logic                votacao,
  output logic                timeout,
  output logic [JW-1:0]       jogador_atual,
  output logic [RODADA_W-1:0] rodada,
  output logic [4:0]          db_estado
);

  // state          | meaning
  // INICIAL        | idle, datapath held clear
  // RESETA_TUDO    | clear player index, round count and datapath
  // PREPARA_JOGO   | wait for confirmation to store the game seed
  // ARMAZENA_JOGO  | seed register load
  // PREPARA_JOGO_2 | settle after seed load
  // PREPARA_NOITE  | first player, load night-turn time
  // TURNO_NOITE    | current player's night turn
  // PROX_JOGADOR   | advance player or end the night
  // PREPARA_DIA    | load discussion time
  // DISCUSSAO      | day discussion
  // VOTACAO        | vote, waits for confirmation only
  // APURA          | count the round, check for a winner
  // FIM            | game over, wait for restart
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    RESETA_TUDO    = 4'd1,
    PREPARA_JOGO   = 4'd2,
    ARMAZENA_JOGO  = 4'd3,
    PREPARA_JOGO_2 = 4'd4,
    PREPARA_NOITE  = 4'd5,
    TURNO_NOITE    = 4'd6,
    PROX_JOGADOR   = 4'd7,
    PREPARA_DIA    = 4'd8,
    DISCUSSAO      = 4'd9,
    VOTACAO        = 4'd10,
    APURA          = 4'd11,
    FIM            = 4'd12
  } estado_t;

  estado_t estado, prox;
  logic    expira;
  logic    ultimo;

  assign ultimo = (jogador_atual == JW'(NUM_JOGADORES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox       = estado;
    rst_global = 1'b0;
    zera_CS    = 1'b0;
    e_seed_reg = 1'b0;
    noite      = 1'b0;
    dia        = 1'b0;
    votacao    = 1'b0;
    db_estado  = {1'b0, estado};
    case (estado)
      INICIAL: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        if (jogar) prox = RESETA_TUDO;
      end
      RESETA_TUDO: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        prox       = PREPARA_JOGO;
      end
      PREPARA_JOGO:   if (passa) prox = ARMAZENA_JOGO;
      ARMAZENA_JOGO: begin
        e_seed_reg = 1'b1;
        prox       = PREPARA_JOGO_2;
      end
      PREPARA_JOGO_2: prox = PREPARA_NOITE;
      PREPARA_NOITE:  prox = TURNO_NOITE;
      TURNO_NOITE: begin
        noite = 1'b1;
        if (passa || expira) prox = PROX_JOGADOR;
      end
      PROX_JOGADOR:   prox = ultimo ? PREPARA_DIA : TURNO_NOITE;
      PREPARA_DIA:    prox = DISCUSSAO;
      DISCUSSAO: begin
        dia = 1'b1;
        if (passa || expira) prox = VOTACAO;
      end
      VOTACAO: begin
        votacao = 1'b1;
        if (passa) prox = APURA;
      end
      APURA:          prox = fim_jogo ? FIM : PREPARA_NOITE;
      FIM:            if (jogar) prox = RESETA_TUDO;
      default: begin
        db_estado = 5'b11111;
        prox      = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogador_atual <= '0;
      rodada        <= '0;
    end else begin
      case (estado)
        RESETA_TUDO: begin
          jogador_atual <= '0;
          rodada        <= '0;
        end
        PREPARA_NOITE: jogador_atual <= '0;
        PROX_JOGADOR:  if (!ultimo) jogador_atual <= jogador_atual + JW'(1);
        APURA:         if (rodada != '1) rodada <= rodada + RODADA_W'(1);
        default: ;
      endcase
    end
  end

`ifdef TEMPORIZADOR_EN
  logic [TEMPO_W-1:0] tempo;
  logic               em_fase;

  assign em_fase = (estado == TURNO_NOITE) || (estado == DISCUSSAO);
  assign expira  = em_fase && (tempo == '0);
  // Expiry coinciding with passa counts as a normal confirm, not a timeout.
  assign timeout = expira && !passa;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tempo <= '0;
    else if (estado == PREPARA_NOITE || (estado == PROX_JOGADOR && !ultimo))
      tempo <= TEMPO_W'(TEMPO_TURNO);
    else if (estado == PREPARA_DIA)
      tempo <= TEMPO_W'(TEMPO_DIA);
    else if (em_fase && tick && tempo != '0)
      tempo <= tempo - TEMPO_W'(1);
  end
`else
  logic [TEMPO_W-1:0] unused_tempo;

  assign unused_tempo = TEMPO_W'(TEMPO_TURNO) ^ TEMPO_W'(TEMPO_DIA) ^ {TEMPO_W{tick}};
  assign expira       = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule
